// File: rtl/input_conditioner.sv
// Pushbutton/sensor front-end: 2-FF sync, per-channel stability filter, rising-edge pulses, test long-press FSM.
// Optional INPUT_AUTO_REPEAT_EN: food/heal re-pulse every REPEAT_CYCLES while held.
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES      = 1000000,
    parameter int unsigned SENSOR_FILTER_CYCLES = 250000,
    parameter int unsigned HOLD_CYCLES          = 150000000,
    parameter int unsigned REPEAT_CYCLES        = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic food_btn_raw,
    input  logic heal_btn_raw,
    input  logic test_btn_raw,
    input  logic light_raw,
    input  logic echo_raw,
    output logic food_button,
    output logic heal_button,
    output logic test_button,
    output logic light_signal,
    output logic echo_signal,
    output logic test_holding
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SF_W   = $clog2(SENSOR_FILTER_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SF_W-1:0]   SF_LAST   = SF_W'(SENSOR_FILTER_CYCLES - 1);
    // The pulse registers on the edge where the hold count would reach HOLD_CYCLES-1.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 2);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LATCHED = 2'd2
    } test_state_t;

    // Channel order: 0 food, 1 heal, 2 test, 3 light, 4 echo.
    logic [4:0] raw_w;
    logic [4:0] s1_q, s2_q;
    logic [4:0] stable_q, stable_d;
    logic [4:0] rise;
    logic [4:0] pulse_q, pulse_d;

    logic [DB_W-1:0] btn_cnt_q [3];
    logic [DB_W-1:0] btn_cnt_d [3];
    logic [SF_W-1:0] sen_cnt_q [2];
    logic [SF_W-1:0] sen_cnt_d [2];

    test_state_t       state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              test_pulse_d;

    logic [1:0]        rep_pulse;
    logic [REP_W-1:0]  rep_q [2];
    logic [REP_W-1:0]  rep_d [2];

    assign raw_w = {echo_raw, light_raw, test_btn_raw, heal_btn_raw, food_btn_raw};

    always_comb begin
        stable_d = stable_q;
        rise     = '0;
        for (int i = 0; i < 3; i++) begin
            btn_cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (btn_cnt_q[i] >= DB_LAST) begin
                    stable_d[i] = s2_q[i];
                    rise[i]     = s2_q[i];
                end else begin
                    btn_cnt_d[i] = btn_cnt_q[i] + DB_W'(1);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            sen_cnt_d[i] = '0;
            if (s2_q[i+3] != stable_q[i+3]) begin
                if (sen_cnt_q[i] >= SF_LAST) begin
                    stable_d[i+3] = s2_q[i+3];
                    rise[i+3]     = s2_q[i+3];
                end else begin
                    sen_cnt_d[i] = sen_cnt_q[i] + SF_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        test_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (stable_q[2]) begin
                    state_d = PRESSED;
                    hold_d  = '0;
                end
            end
            PRESSED: begin
                if (!stable_q[2]) begin
                    state_d = IDLE;
                end else if (hold_q >= HOLD_LAST) begin
                    test_pulse_d = 1'b1;
                    state_d      = LATCHED;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            LATCHED: begin
                if (!stable_q[2]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef INPUT_AUTO_REPEAT_EN
    // Repeat timing pauses while a release is being qualified, so a release never emits a stray repeat.
    always_comb begin
        rep_pulse = '0;
        for (int i = 0; i < 2; i++) begin
            rep_d[i] = rep_q[i];
            if (!stable_q[i] || rise[i]) begin
                rep_d[i] = '0;
            end else if (s2_q[i] == stable_q[i]) begin
                if (rep_q[i] >= REP_LAST) begin
                    rep_pulse[i] = 1'b1;
                    rep_d[i]     = '0;
                end else begin
                    rep_d[i] = rep_q[i] + REP_W'(1);
                end
            end
        end
    end
`else
    always_comb begin
        rep_pulse = '0;
        for (int i = 0; i < 2; i++) rep_d[i] = '0;
    end
`endif

    always_comb begin
        pulse_d    = rise;
        pulse_d[0] = rise[0] | rep_pulse[0];
        pulse_d[1] = rise[1] | rep_pulse[1];
        pulse_d[2] = test_pulse_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            pulse_q  <= '0;
            state_q  <= IDLE;
            hold_q   <= '0;
            for (int i = 0; i < 3; i++) btn_cnt_q[i] <= '0;
            for (int i = 0; i < 2; i++) begin
                sen_cnt_q[i] <= '0;
                rep_q[i]     <= '0;
            end
        end else begin
            s1_q     <= raw_w;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            state_q  <= state_d;
            hold_q   <= hold_d;
            for (int i = 0; i < 3; i++) btn_cnt_q[i] <= btn_cnt_d[i];
            for (int i = 0; i < 2; i++) begin
                sen_cnt_q[i] <= sen_cnt_d[i];
                rep_q[i]     <= rep_d[i];
            end
        end
    end

    assign food_button  = pulse_q[0];
    assign heal_button  = pulse_q[1];
    assign test_button  = pulse_q[2];
    assign light_signal = pulse_q[3];
    assign echo_signal  = pulse_q[4];
    assign test_holding = (state_q == PRESSED);

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: expected pulses are queued with their due cycle and checked by a monitor.
module tb_input_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic food_btn_raw, heal_btn_raw, test_btn_raw, light_raw, echo_raw;
    logic food_button, heal_button, test_button, light_signal, echo_signal, test_holding;

    input_conditioner #(
        .DEBOUNCE_CYCLES     (4),
        .SENSOR_FILTER_CYCLES(3),
        .HOLD_CYCLES         (16),
        .REPEAT_CYCLES       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .food_btn_raw(food_btn_raw),
        .heal_btn_raw(heal_btn_raw),
        .test_btn_raw(test_btn_raw),
        .light_raw   (light_raw),
        .echo_raw    (echo_raw),
        .food_button (food_button),
        .heal_button (heal_button),
        .test_button (test_button),
        .light_signal(light_signal),
        .echo_signal (echo_signal),
        .test_holding(test_holding)
    );

    // Clock and edge counter: cyc equals the number of rising edges seen so far.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Entry = {due cycle[15:0], pulse vector {food, heal, test, light, echo}}.
    logic [20:0] exp_q[$];
    logic [4:0]  obs_vec;
    assign obs_vec = {food_button, heal_button, test_button, light_signal, echo_signal};

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic expect_pulse(input int at, input logic [4:0] vec);
        logic [15:0] at16;
        at16 = 16'(at);
        exp_q.push_back({at16, vec});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Scoreboard monitor: any pulse, or any due expectation, produces one comparison.
    always @(negedge clk) begin
        logic [4:0] exp_now;
        exp_now = '0;
        if (exp_q.size() != 0 && int'(exp_q[0][20:5]) <= cyc) begin
            exp_now = exp_q[0][4:0];
            void'(exp_q.pop_front());
        end
        if (obs_vec != 5'b0 || exp_now != 5'b0)
            check($sformatf("pulses@%0d", cyc), obs_vec, exp_now);
    end

    initial begin
        int k;
        int m;
        rst          = 1'b1;
        food_btn_raw = 1'b0;
        heal_btn_raw = 1'b0;
        test_btn_raw = 1'b0;
        light_raw    = 1'b0;
        echo_raw     = 1'b0;

        // Reset state
        step(3);
        check("reset_pulses", obs_vec, 5'b0);
        check("reset_holding", {4'b0, test_holding}, 5'b0);
        rst = 1'b0;
        step(3);

        // Food held 20 cycles: single pulse at edge 6, none on release
        k = cyc;
        food_btn_raw = 1'b1;
        expect_pulse(k + 6, 5'b10000);
`ifdef INPUT_AUTO_REPEAT_EN
        expect_pulse(k + 14, 5'b10000);
        expect_pulse(k + 22, 5'b10000);
`endif
        step(20);
        food_btn_raw = 1'b0;
        step(15);

        // Heal 3-cycle glitch: no pulse
        heal_btn_raw = 1'b1;
        step(3);
        heal_btn_raw = 1'b0;
        step(10);

        // Test held 30 cycles: holding from edge 7, pulse at edge 22, then latched
        k = cyc;
        test_btn_raw = 1'b1;
        expect_pulse(k + 22, 5'b00100);
        wait_to(k + 6);
        check("holding_pre", {4'b0, test_holding}, 5'b0);
        wait_to(k + 7);
        check("holding_start", {4'b0, test_holding}, 5'b1);
        wait_to(k + 21);
        check("holding_last", {4'b0, test_holding}, 5'b1);
        wait_to(k + 22);
        check("holding_latched", {4'b0, test_holding}, 5'b0);
        wait_to(k + 30);
        check("holding_still_latched", {4'b0, test_holding}, 5'b0);
        test_btn_raw = 1'b0;
        step(15);

        // Fresh long press after release pulses again
        k = cyc;
        test_btn_raw = 1'b1;
        expect_pulse(k + 22, 5'b00100);
        wait_to(k + 24);
        test_btn_raw = 1'b0;
        step(15);

        // Test held 10 cycles: no pulse, back to idle after release debounce
        k = cyc;
        test_btn_raw = 1'b1;
        wait_to(k + 7);
        check("short_holding", {4'b0, test_holding}, 5'b1);
        wait_to(k + 10);
        test_btn_raw = 1'b0;
        wait_to(k + 16);
        check("short_release_pending", {4'b0, test_holding}, 5'b1);
        wait_to(k + 17);
        check("short_back_idle", {4'b0, test_holding}, 5'b0);
        step(10);

        // Food, light, echo, test together; reset mid-hold, inputs held through release
        k = cyc;
        food_btn_raw = 1'b1;
        light_raw    = 1'b1;
        echo_raw     = 1'b1;
        test_btn_raw = 1'b1;
        expect_pulse(k + 5, 5'b00011);
        expect_pulse(k + 6, 5'b10000);
        wait_to(k + 12);
        check("simul_holding", {4'b0, test_holding}, 5'b1);
        rst = 1'b1;
        step(1);
        check("midreset_pulses", obs_vec, 5'b0);
        check("midreset_holding", {4'b0, test_holding}, 5'b0);
        step(1);
        rst = 1'b0;
        m = cyc;
        expect_pulse(m + 5, 5'b00011);
        expect_pulse(m + 6, 5'b10000);
`ifdef INPUT_AUTO_REPEAT_EN
        expect_pulse(m + 14, 5'b10000);
        expect_pulse(m + 22, 5'b10100);
`else
        expect_pulse(m + 22, 5'b00100);
`endif
        wait_to(m + 7);
        check("requal_holding", {4'b0, test_holding}, 5'b1);
        wait_to(m + 25);
        food_btn_raw = 1'b0;
        light_raw    = 1'b0;
        echo_raw     = 1'b0;
        test_btn_raw = 1'b0;
        step(15);

`ifdef INPUT_AUTO_REPEAT_EN
        // Food held 40 cycles: repeats every 8 cycles after the first pulse
        k = cyc;
        food_btn_raw = 1'b1;
        expect_pulse(k + 6, 5'b10000);
        expect_pulse(k + 14, 5'b10000);
        expect_pulse(k + 22, 5'b10000);
        expect_pulse(k + 30, 5'b10000);
        expect_pulse(k + 38, 5'b10000);
        step(40);
        food_btn_raw = 1'b0;
        step(15);
`endif

        // Every queued expectation must have been consumed
        step(5);
        n_vec++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL queue_drained observed=%0d expected=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end for the pet state machine.
- Takes raw asynchronous pushbuttons and the light/echo sensor levels and synchronises and debounces them.
- Emits one-cycle request pulses (food_button, heal_button, test_button, light_signal, echo_signal) that drive the state up/down logic directly.
- test_button fires only after a sustained long-press, so an accidental tap never enters or leaves test mode.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples required to accept a button level change (20 ms at 50 MHz).
- SENSOR_FILTER_CYCLES, 250000: consecutive stable samples required to accept a light/echo level change.
- HOLD_CYCLES, 150000000: debounced test-button hold time before test_button pulses (3 s at 50 MHz).
- REPEAT_CYCLES, 25000000: auto-repeat period. Used only with AUTO_REPEAT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- food_btn_raw  in  1  raw food pushbutton, async, active-high
- heal_btn_raw  in  1  raw heal pushbutton, async, active-high
- test_btn_raw  in  1  raw test pushbutton, async, active-high
- light_raw  in  1  raw light-sensor comparator level
- echo_raw  in  1  raw ultrasonic-echo presence level
- food_button  out  1  one-cycle pulse on accepted food press
- heal_button  out  1  one-cycle pulse on accepted heal press
- test_button  out  1  one-cycle pulse on completed long-press
- light_signal  out  1  one-cycle pulse on accepted light rising level
- echo_signal  out  1  one-cycle pulse on accepted echo rising level
- test_holding  out  1  high while test FSM in PRESSED (for LED feedback)

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous, active-high (rst).
- Synchronisers: every raw input passes through a 2-FF synchroniser. s2 is the synchronised sample.
- Filter, per channel: counter increments each cycle s2 != stable and clears to 0 when s2 == stable. A count of N consecutive differing samples updates stable (N = DEBOUNCE_CYCLES for buttons, SENSOR_FILTER_CYCLES for sensors), and the counter clears.
- Pulses: a 0->1 update of stable sets that channel's pulse register at the same edge; the pulse is high for exactly one cycle. No pulse on 1->0.
- Latency: counting the first edge that samples raw high as edge 1, the pulse registers at edge N+2. Any glitch shorter than N samples produces no pulse.
- Test FSM, on debounced test level tb:
  - IDLE: tb=1 -> PRESSED, hold counter = 0.
  - PRESSED: counter increments per cycle. tb=0 before reaching HOLD_CYCLES-1 -> IDLE, no pulse. On reaching HOLD_CYCLES-1 with tb=1: test_button pulses one cycle -> LATCHED.
  - LATCHED: no further pulses. tb=0 -> IDLE.
  - test_holding = (state == PRESSED).
- Counter widths: $clog2(param+1). All counters are saturating; none wraps.
- Independence: channels are independent. Simultaneous pulses on several outputs in one cycle are legal. Food/heal pulses are generated regardless of test FSM state.
- Reset: all synchroniser FFs, stable levels, counters and pulse outputs go to 0; test FSM goes to IDLE; test_holding = 0. Reset mid-press or mid-hold aborts with no pulse. An input held high through reset release is re-qualified from zero and pulses after full debounce, as if newly pressed.

Optional Feature:
- Macro: INPUT_AUTO_REPEAT_EN.
- Defined: while the food or heal debounced level stays high, that channel re-pulses every REPEAT_CYCLES cycles after its initial pulse. Each channel has its own repeat counter, cleared on release or reset. Sensors and the test channel never repeat.
- Undefined: repeat logic is absent; one pulse per accepted press.

Test Plan (DEBOUNCE_CYCLES=4, SENSOR_FILTER_CYCLES=3, HOLD_CYCLES=16, REPEAT_CYCLES=8):
- food_btn_raw high from edge 1 for 20 cycles -> food_button high only in the cycle after edge 6; no pulse on release.
- heal_btn_raw 3-cycle glitch, then low -> heal_button never asserts; internal counter returns to 0.
- test_btn_raw held 30 cycles -> test_holding high from edge 7; test_button single pulse at edge 22; test_holding low afterward; no second pulse until release and a new 16-cycle hold.
- test_btn_raw held 10 cycles, released -> no test_button pulse; FSM returns to IDLE after release debounce.
- food, light and echo raised on the same edge -> food_button at edge 6 and light_signal/echo_signal together at edge 5; rst asserted mid-hold on test -> all outputs 0, no test pulse.
- INPUT_AUTO_REPEAT_EN defined, food held 40 cycles -> food_button pulses at edges 6, 14, 22, 30, 38.
